// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 keystream engine.
// Optional feature macro: RC4_DROP_EN (adds the keystream-drop states).
package rc4_pkg;

    localparam int S_SIZE = 256;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        KEYLOAD = 4'd1,
        INIT    = 4'd2,
        KSA_RD  = 4'd3,
        KSA_SW  = 4'd4,
`ifdef RC4_DROP_EN
        DROP_RD = 4'd5,
        DROP_SW = 4'd6,
`endif
        RUN_RD  = 4'd7,
        RUN_SW  = 4'd8,
        RUN_OUT = 4'd9
    } rc4_state_e;

    // A session key length is usable when it is non-zero and fits the key store.
    function automatic logic key_len_ok(input logic [8:0] len, input int unsigned max_len);
        return (len != 9'd0) && (32'(len) <= max_len);
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256x8 permutation store with two combinational read ports and
// two write ports, so a full S[i]/S[j] swap retires in a single clock.
// The contents are deliberately not reset; INIT rebuilds them every session.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic [BYTE_W-1:0] ra_addr_i,
    output logic [BYTE_W-1:0] ra_data_o,
    input  logic [BYTE_W-1:0] rb_addr_i,
    output logic [BYTE_W-1:0] rb_data_o,
    input  logic              wa_en_i,
    input  logic [BYTE_W-1:0] wa_addr_i,
    input  logic [BYTE_W-1:0] wa_data_i,
    input  logic              wb_en_i,
    input  logic [BYTE_W-1:0] wb_addr_i,
    input  logic [BYTE_W-1:0] wb_data_i
);

    logic [BYTE_W-1:0] s_mem [S_SIZE];

    assign ra_data_o = s_mem[ra_addr_i];
    assign rb_data_o = s_mem[rb_addr_i];

    // Two write ports; when both hit the same entry (i==j swap) they carry the same value.
    always_ff @(posedge clk) begin
        if (wa_en_i) begin
            s_mem[wa_addr_i] <= wa_data_i;
        end
        if (wb_en_i) begin
            s_mem[wb_addr_i] <= wb_data_i;
        end
    end

endmodule

// File: rtl/rc4_cipher.sv
// rc4_cipher: RC4 key scheduling plus keystream generation with valid/ready
// handshakes for key bytes, input data and output data.
// Optional feature macro: RC4_DROP_EN (discard DROP_BYTES keystream bytes after KSA).
module rc4_cipher
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_LEN = 16,
    parameter int DROP_BYTES  = 768
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [8:0] key_len,
    input  logic       mode,
    input  logic       key_valid,
    input  logic [7:0] key_data,
    output logic       key_ready,
    input  logic       din_valid,
    input  logic [7:0] din_data,
    output logic       din_ready,
    output logic       dout_valid,
    output logic [7:0] dout_data,
    input  logic       dout_ready,
    output logic       busy,
    output logic       err
);

    localparam int KW = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;

    rc4_state_e state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [7:0]    si_q, si_d, sj_q, sj_d;
    logic [7:0]    din_q, din_d;
    logic [8:0]    key_len_q, key_len_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d, err_q, err_d;
    logic          key_ready_q, key_ready_d, din_ready_q, din_ready_d;
    logic          dout_valid_q, dout_valid_d;
    logic [7:0]    dout_data_q, dout_data_d;
`ifdef RC4_DROP_EN
    logic [31:0]   drop_cnt_q, drop_cnt_d;
`endif

    logic [7:0] key_mem [MAX_KEY_LEN];
    logic       key_we_s;
    logic [7:0] key_byte_s;
    logic       k_last_s;
    logic [7:0] j_new_s, ks_byte_s;
    logic [7:0] ra_addr_s, ra_data_s, rb_addr_s, rb_data_s;
    logic       wa_en_s, wb_en_s;
    logic [7:0] wa_addr_s, wa_data_s, wb_addr_s, wb_data_s;

    rc4_sbox u_sbox (
        .clk       (clk),
        .ra_addr_i (ra_addr_s),
        .ra_data_o (ra_data_s),
        .rb_addr_i (rb_addr_s),
        .rb_data_o (rb_data_s),
        .wa_en_i   (wa_en_s),
        .wa_addr_i (wa_addr_s),
        .wa_data_i (wa_data_s),
        .wb_en_i   (wb_en_s),
        .wb_addr_i (wb_addr_s),
        .wb_data_i (wb_data_s)
    );

    assign key_byte_s = key_mem[k_q];
    assign k_last_s   = ((9'(k_q) + 9'd1) == key_len_q);

    // Key store: one byte per accepted beat, contents survive reset.
    always_ff @(posedge clk) begin
        if (key_we_s) begin
            key_mem[k_q] <= key_data;
        end
    end

    // First read address: S[i] in KSA, S[i+1] when generating, S[S[i]+S[j]] for the output byte.
    always_comb begin
        ra_addr_s = i_q;
        case (state_q)
            RUN_RD:  ra_addr_s = i_q + 8'd1;
`ifdef RC4_DROP_EN
            DROP_RD: ra_addr_s = i_q + 8'd1;
`endif
            RUN_SW:  ra_addr_s = si_q + sj_q;
            default: ra_addr_s = i_q;
        endcase
    end

    // New j and the second read address S[j_new], chained off the first read.
    always_comb begin
        if (state_q == KSA_RD) begin
            j_new_s = j_q + ra_data_s + key_byte_s;
        end else begin
            j_new_s = j_q + ra_data_s;
        end
        rb_addr_s = j_new_s;
    end

    // Output byte read after the swap; forward the swapped values when the index hits i or j.
    always_comb begin
        if (ra_addr_s == i_q) begin
            ks_byte_s = sj_q;
        end else if (ra_addr_s == j_q) begin
            ks_byte_s = si_q;
        end else begin
            ks_byte_s = ra_data_s;
        end
    end

    // Next-state and datapath control; start overrides whatever the current state wants.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        din_d       = din_q;
        key_len_d   = key_len_q;
        mode_d      = mode_q;
        busy_d      = busy_q;
        err_d       = err_q;
        dout_data_d = dout_data_q;
`ifdef RC4_DROP_EN
        drop_cnt_d  = drop_cnt_q;
`endif
        key_we_s    = 1'b0;
        wa_en_s     = 1'b0;
        wa_addr_s   = i_q;
        wa_data_s   = sj_q;
        wb_en_s     = 1'b0;
        wb_addr_s   = j_q;
        wb_data_s   = si_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            KEYLOAD: begin
                if (key_valid && key_ready_q) begin
                    key_we_s = 1'b1;
                    if (k_last_s) begin
                        k_d     = '0;
                        i_d     = 8'd0;
                        state_d = INIT;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    key_we_s = 1'b0;
                end
            end
            INIT: begin
                wa_en_s   = 1'b1;
                wa_addr_s = i_q;
                wa_data_s = i_q;
                i_d       = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = KSA_RD;
                end else begin
                    state_d = INIT;
                end
            end
            KSA_RD: begin
                si_d    = ra_data_s;
                sj_d    = rb_data_s;
                j_d     = j_new_s;
                state_d = KSA_SW;
            end
            KSA_SW: begin
                wa_en_s = 1'b1;
                wb_en_s = 1'b1;
                i_d     = i_q + 8'd1;
                if (k_last_s) begin
                    k_d = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
                if (i_q == 8'd255) begin
                    j_d = 8'd0;
`ifdef RC4_DROP_EN
                    if (DROP_BYTES == 0) begin
                        state_d = RUN_RD;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = DROP_RD;
                        drop_cnt_d = 32'(DROP_BYTES);
                    end
`else
                    state_d = RUN_RD;
                    busy_d  = 1'b0;
`endif
                end else begin
                    state_d = KSA_RD;
                end
            end
`ifdef RC4_DROP_EN
            DROP_RD: begin
                i_d     = i_q + 8'd1;
                si_d    = ra_data_s;
                sj_d    = rb_data_s;
                j_d     = j_new_s;
                state_d = DROP_SW;
            end
            DROP_SW: begin
                wa_en_s    = 1'b1;
                wb_en_s    = 1'b1;
                drop_cnt_d = drop_cnt_q - 32'd1;
                if (drop_cnt_q == 32'd1) begin
                    state_d = RUN_RD;
                    busy_d  = 1'b0;
                end else begin
                    state_d = DROP_RD;
                end
            end
`endif
            RUN_RD: begin
                if (mode_q || (din_valid && din_ready_q)) begin
                    i_d     = i_q + 8'd1;
                    si_d    = ra_data_s;
                    sj_d    = rb_data_s;
                    j_d     = j_new_s;
                    din_d   = mode_q ? 8'd0 : din_data;
                    state_d = RUN_SW;
                end else begin
                    state_d = RUN_RD;
                end
            end
            RUN_SW: begin
                wa_en_s     = 1'b1;
                wb_en_s     = 1'b1;
                dout_data_d = ks_byte_s ^ din_q;
                state_d     = RUN_OUT;
            end
            RUN_OUT: begin
                if (dout_ready) begin
                    state_d = RUN_RD;
                end else begin
                    state_d = RUN_OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start) begin
            key_we_s = 1'b0;
            if (key_len_ok(key_len, MAX_KEY_LEN)) begin
                err_d     = 1'b0;
                busy_d    = 1'b1;
                key_len_d = key_len;
                mode_d    = mode;
                i_d       = 8'd0;
                j_d       = 8'd0;
                k_d       = '0;
                state_d   = KEYLOAD;
            end else begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        end else begin
            key_len_d = key_len_q;
        end

        key_ready_d  = (state_d == KEYLOAD);
        din_ready_d  = (state_d == RUN_RD) && !mode_d;
        dout_valid_d = (state_d == RUN_OUT);
    end

    // State, index and output registers; S and key storage are outside this reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            i_q          <= 8'd0;
            j_q          <= 8'd0;
            k_q          <= '0;
            si_q         <= 8'd0;
            sj_q         <= 8'd0;
            din_q        <= 8'd0;
            key_len_q    <= 9'd0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            key_ready_q  <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= 8'd0;
`ifdef RC4_DROP_EN
            drop_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            si_q         <= si_d;
            sj_q         <= sj_d;
            din_q        <= din_d;
            key_len_q    <= key_len_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            key_ready_q  <= key_ready_d;
            din_ready_q  <= din_ready_d;
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
`ifdef RC4_DROP_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign key_ready  = key_ready_q;
    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rc4_cipher.sv
// tb_rc4_cipher: self-checking bench for rc4_cipher with a plain RC4 reference model.
// Honours RC4_DROP_EN (then the DUT is built with DROP_BYTES=1).
module tb_rc4_cipher;

`ifdef RC4_DROP_EN
    localparam int DROP_N     = 1;
    localparam int DROP_PARAM = 1;
`else
    localparam int DROP_N     = 0;
    localparam int DROP_PARAM = 768;
`endif
    localparam int MAXK = 16;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [8:0] key_len;
    logic       mode;
    logic       key_valid;
    logic [7:0] key_data;
    logic       key_ready;
    logic       din_valid;
    logic [7:0] din_data;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout_data;
    logic       dout_ready;
    logic       busy;
    logic       err;

    rc4_cipher #(.MAX_KEY_LEN(MAXK), .DROP_BYTES(DROP_PARAM)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .key_len    (key_len),
        .mode       (mode),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int stall_n = 0;

    logic [7:0] exp_q[$];
    int         hs_cyc[$];
    logic [7:0] sess_key [0:255];
    logic [7:0] sess_din [0:63];
    logic [7:0] mdl_key  [0:255];
    logic [7:0] mdl_ks   [0:63];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Textbook RC4: KSA, then drop + n bytes of PRGA; results land in mdl_ks.
    task automatic model_ks(input int klen, input int n, input int drop);
        int s [256];
        int i;
        int j;
        int t;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + int'(mdl_key[x % klen])) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int c = 0; c < drop + n; c++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (c >= drop) mdl_ks[c - drop] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic set_key_str(input string s);
        for (int b = 0; b < s.len(); b++) sess_key[b] = s[b];
    endtask

    task automatic set_din_str(input string s);
        for (int b = 0; b < s.len(); b++) sess_din[b] = s[b];
    endtask

    // dout_ready driver: hold off stall_n cycles per byte, only while bytes are expected.
    initial begin
        int wcnt;
        wcnt = 0;
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dout_valid && (exp_q.size() > 0) && (wcnt >= stall_n)) dout_ready = 1'b1;
            else dout_ready = 1'b0;
            if (dout_valid) wcnt++;
            else wcnt = 0;
        end
    end

    // Output compare: every accepted byte against the expectation queue, held bytes must not move.
    initial begin
        logic       hold_v;
        logic [7:0] hold_d;
        logic [7:0] e;
        hold_v = 1'b0;
        hold_d = 8'd0;
        forever begin
            @(negedge clk);
            if (dout_valid && hold_v) begin
                checks++;
                if (dout_data !== hold_d) begin
                    errors++;
                    $display("FAIL dout_stable: got %02h required %02h", dout_data, hold_d);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dout_extra: got %02h required no byte", dout_data);
                end else begin
                    e = exp_q.pop_front();
                    hs_cyc.push_back(cyc);
                    if (dout_data !== e) begin
                        errors++;
                        $display("FAIL dout_byte: got %02h required %02h", dout_data, e);
                    end
                end
            end
            hold_v = dout_valid && !dout_ready;
            hold_d = dout_data;
        end
    end

    task automatic pulse_start(input int klen, input logic m);
        start   = 1'b1;
        key_len = 9'(klen);
        mode    = m;
        tick();
        start   = 1'b0;
    endtask

    task automatic load_key(input int klen);
        int cnt;
        bit hs;
        for (int b = 0; b < klen; b++) begin
            key_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
            key_valid = 1'b1;
            key_data  = sess_key[b];
            cnt = 0;
            hs  = 1'b0;
            while (!hs && cnt < 1000) begin
                @(negedge clk);
                hs = key_ready;
                tick();
                cnt++;
            end
            if (!hs) fail_timeout("key_handshake");
        end
        key_valid = 1'b0;
    endtask

    task automatic feed_din(input int n);
        int cnt;
        bit hs;
        for (int b = 0; b < n; b++) begin
            din_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
            din_valid = 1'b1;
            din_data  = sess_din[b];
            cnt = 0;
            hs  = 1'b0;
            while (!hs && cnt < 8000) begin
                @(negedge clk);
                hs = din_ready;
                tick();
                cnt++;
            end
            if (!hs) fail_timeout("din_handshake");
        end
        din_valid = 1'b0;
    endtask

    task automatic run_session(input int klen, input logic m, input int n, input int stall, input bit lat_chk);
        int cnt;
        stall_n = stall;
        pulse_start(klen, m);
        chk("start_err_clear", 32'(err), 32'd0);
        chk("start_busy_set", 32'(busy), 32'd1);
        for (int b = 0; b < klen; b++) mdl_key[b] = sess_key[b];
        model_ks(klen, n, DROP_N);
        hs_cyc.delete();
        for (int c = 0; c < n; c++) exp_q.push_back(m ? mdl_ks[c] : (mdl_ks[c] ^ sess_din[c]));
        load_key(klen);
        if (lat_chk) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (busy && cnt < 8000);
            if (busy) fail_timeout("busy_fall");
            chk("latency_rr0", 32'(dout_valid), 32'd0);
            @(negedge clk);
            chk("latency_rr1", 32'(dout_valid), 32'd0);
            @(negedge clk);
            chk("latency_rr2", 32'(dout_valid), 32'd1);
            tick();
        end
        if (!m) feed_din(n);
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 20000) begin
            tick();
            cnt++;
        end
        if (exp_q.size() > 0) begin
            fail_timeout("dout_drain");
            exp_q.delete();
        end
        if (lat_chk) begin
            if (hs_cyc.size() == n) chk("throughput", 32'(hs_cyc[n-1] - hs_cyc[0]), 32'(3 * (n - 1)));
            else chk("throughput_count", 32'(hs_cyc.size()), 32'(n));
        end
    endtask

    initial begin
        logic [7:0] lit_key [0:9];
        logic [7:0] lit_sec [0:13];
        logic [7:0] lit_wik [0:4];
        bit seen;
        int klen;
        int n;
        logic m;

        lit_key = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        lit_sec = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38, 8'h35, 8'h52,
                    8'h54, 8'h4B, 8'h9B, 8'hF5};
        lit_wik = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

        reset_n   = 1'b0;
        start     = 1'b0;
        key_len   = 9'd0;
        mode      = 1'b0;
        key_valid = 1'b0;
        key_data  = 8'd0;
        din_valid = 1'b0;
        din_data  = 8'd0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_key_ready", 32'(key_ready), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout_data", 32'(dout_data), 32'd0);
        reset_n = 1'b1;
        tick();

        // Pin the reference model to the published vectors.
        set_key_str("Key");
        for (int b = 0; b < 3; b++) mdl_key[b] = sess_key[b];
        model_ks(3, 10, 0);
        for (int b = 0; b < 10; b++) chk("model_key", 32'(mdl_ks[b]), 32'(lit_key[b]));
        model_ks(3, 1, 1);
        chk("model_drop1", 32'(mdl_ks[0]), 32'h9F);
        set_key_str("Secret");
        set_din_str("Attack at dawn");
        for (int b = 0; b < 6; b++) mdl_key[b] = sess_key[b];
        model_ks(6, 14, 0);
        for (int b = 0; b < 14; b++) chk("model_secret", 32'(mdl_ks[b] ^ sess_din[b]), 32'(lit_sec[b]));
        set_key_str("Wiki");
        set_din_str("pedia");
        for (int b = 0; b < 4; b++) mdl_key[b] = sess_key[b];
        model_ks(4, 5, 0);
        for (int b = 0; b < 5; b++) chk("model_wiki", 32'(mdl_ks[b] ^ sess_din[b]), 32'(lit_wik[b]));

        // Illegal key lengths set err and park in IDLE.
        pulse_start(0, 1'b1);
        chk("illegal0_err", 32'(err), 32'd1);
        chk("illegal0_busy", 32'(busy), 32'd0);
        chk("illegal0_key_ready", 32'(key_ready), 32'd0);
        pulse_start(MAXK + 1, 1'b1);
        chk("illegal_max_err", 32'(err), 32'd1);
        chk("illegal_max_key_ready", 32'(key_ready), 32'd0);

        // Published vectors (the first also checks latency and peak rate).
        set_key_str("Key");
        run_session(3, 1'b1, 10, 0, 1'b1);
        set_key_str("Secret");
        set_din_str("Attack at dawn");
        run_session(6, 1'b0, 14, 1, 1'b0);
        set_key_str("Wiki");
        set_din_str("pedia");
        run_session(4, 1'b0, 5, 10, 1'b0);

        // Restart while a byte is held in the output stage.
        set_key_str("Key");
        run_session(3, 1'b1, 3, 0, 1'b0);
        repeat (5) tick();
        set_key_str("Wiki");
        run_session(4, 1'b1, 4, 0, 1'b0);

        // Reset in the middle of KSA: outputs clear at once and stay quiet without a start.
        set_key_str("Secret");
        pulse_start(6, 1'b0);
        load_key(6);
        repeat (300) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
        chk("midrst_dout_data", 32'(dout_data), 32'd0);
        chk("midrst_key_ready", 32'(key_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (dout_valid || busy) seen = 1'b1;
        end
        chk("midrst_quiet", 32'(seen), 32'd0);
        set_key_str("Key");
        run_session(3, 1'b1, 4, 0, 1'b0);

        // Randomized sessions, including the key length boundaries.
        for (int r = 0; r < 6; r++) begin
            if (r == 0) klen = 1;
            else if (r == 1) klen = MAXK;
            else klen = $urandom_range(1, MAXK);
            n = $urandom_range(4, 12);
            m = 1'($urandom_range(0, 1));
            for (int b = 0; b < klen; b++) sess_key[b] = 8'($urandom_range(0, 255));
            for (int b = 0; b < n; b++) sess_din[b] = 8'($urandom_range(0, 255));
            run_session(klen, m, n, $urandom_range(0, 3), 1'b0);
        end

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_cipher.md
RC4_CIPHER -- requirements
Module: rc4_cipher

Interface
REQ-001 SHALL have parameter MAX_KEY_LEN, default 16, maximum key bytes stored (legal range 1..256).
REQ-002 SHALL have parameter DROP_BYTES, default 768, number of keystream bytes discarded after KSA (used only under RC4_DROP_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a new session.
REQ-006 SHALL have port key_len, input, 9, key length in bytes, sampled when start is high.
REQ-007 SHALL have port mode, input, 1, 0 = XOR din into keystream, 1 = raw keystream; sampled when start is high.
REQ-008 SHALL have ports key_valid (input, 1), key_data (input, 8) and key_ready (output, 1), forming the key byte handshake.
REQ-009 SHALL have ports din_valid (input, 1), din_data (input, 8) and din_ready (output, 1), forming the plaintext/ciphertext handshake.
REQ-010 SHALL have ports dout_valid (output, 1), dout_data (output, 8) and dout_ready (input, 1), forming the result handshake.
REQ-011 SHALL have port busy, output, 1, high from start until the first RUN_RD cycle.
REQ-012 SHALL have port err, output, 1, sticky illegal-key_len flag.

Function
REQ-013 SHALL use states IDLE, KEYLOAD, INIT, KSA_RD, KSA_SW, DROP_RD, DROP_SW, RUN_RD, RUN_SW and RUN_OUT.
REQ-014 start with key_len in 1..MAX_KEY_LEN SHALL clear err, set busy and enter KEYLOAD.
REQ-015 start with any other key_len SHALL set err and enter IDLE.
REQ-016 start SHALL be honoured in every state and abort any session in progress.
REQ-017 KEYLOAD SHALL assert key_ready, store one byte per key_valid&key_ready beat, and enter INIT after key_len beats.
REQ-018 INIT SHALL write S[i]=i for i=0..255, one entry per cycle (256 cycles), then clear i, j and k.
REQ-019 KSA_RD SHALL compute j=j+S[i]+key[k] (8-bit wrap).
REQ-020 KSA_SW SHALL swap S[i] and S[j], increment i, and wrap k to 0 at key_len (no modulo operator).
REQ-021 KSA SHALL take exactly 512 cycles, exiting after i=255.
REQ-022 Each generated byte SHALL use i=i+1, j=j+S[i], swap S[i]/S[j], then K=S[S[i]+S[j]], all 8-bit wrap.
REQ-023 i and j SHALL both be 0 at the first RUN_RD or DROP_RD.
REQ-024 RUN_RD SHALL advance only if mode=1, or din_valid=1 with mode=0.
REQ-025 din_ready SHALL be high only in RUN_RD with mode=0, so the din byte is consumed on the RUN_RD beat.
REQ-026 RUN_SW SHALL register dout_data as K XOR din byte (mode 0) or K (mode 1).
REQ-027 RUN_OUT SHALL hold dout_valid=1 with dout_data stable until dout_ready, then return to RUN_RD.
REQ-028 Peak throughput SHALL be one byte per 3 cycles; the first dout_valid SHALL occur 2 cycles after RUN_RD is entered with input available.
REQ-029 When i==j the swap SHALL leave S unchanged.
REQ-030 i SHALL wrap 255->0 without stopping generation.

Reset
REQ-031 reset_n low SHALL immediately force IDLE and clear i, j, k, busy, err, key_ready, din_ready, dout_valid and dout_data (0x00).
REQ-032 S and key contents SHALL NOT be reset.
REQ-033 Reset mid-session SHALL require a new start before any output.

Configuration
REQ-034 With macro RC4_DROP_EN defined, after KSA the block SHALL run DROP_BYTES iterations of DROP_RD/DROP_SW (2 cycles each, no handshakes, busy high) before RUN_RD.
REQ-035 Without RC4_DROP_EN, KSA SHALL go directly to RUN_RD, DROP states SHALL be absent, and DROP_BYTES SHALL be ignored.

Structure
REQ-036 Package rc4_pkg SHALL hold the state enum, S_SIZE=256 and BYTE_W=8.
REQ-037 Sub-module rc4_sbox SHALL hold the 256x8 S array with two asynchronous read ports and two write ports, so a swap completes in one cycle.

Verification
REQ-038 Key "Key" (4B 65 79), mode 1 -> dout EB 9F 77 81 B7 34 CA 72 A7 19.
REQ-039 Key "Secret", mode 0, din "Attack at dawn" -> 45 A0 1F 64 5F C3 5B 38 35 52 54 4B 9B F5.
REQ-040 Key "Wiki", mode 0, din "pedia", dout_ready low 10 cycles per byte -> 10 21 BF 04 20 with data held stable while stalled.
REQ-041 start with key_len=0, then MAX_KEY_LEN+1 -> err=1 and IDLE; next legal start -> err=0.
REQ-042 reset_n low mid-KSA, then start with key "Key" -> first byte EB; start mid-RUN with key "Wiki" -> first byte 60.
REQ-043 With RC4_DROP_EN and DROP_BYTES=1, key "Key", mode 1 -> first dout 9F.
